// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch-front-end types and constants for the 16-bit MIPS core
package mips_pkg;

  localparam int WORD_W      = 16;
  localparam int INSTR_BYTES = 2;

  localparam logic [WORD_W-1:0] NOP_INSTR_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP,
    FULL
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - req/ack instruction-memory bus between fetch unit and imem
interface instr_fetch_unit_if;
  import mips_pkg::*;

  logic              imem_req;
  logic [WORD_W-1:0] imem_addr;
  logic              imem_ack;
  logic [WORD_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner, imem requester, one-entry skid and IF/ID output slot
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC  = 16'h0000,
  parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                PC_Src,
  input  logic [WORD_W-1:0]   branch_target,
  input  logic                stall,
  instr_fetch_unit_if.master  imem,
  output logic                O_valid,
  output logic [WORD_W-1:0]   O_instruction,
  output logic [WORD_W-1:0]   O_PC_plus_two
);

  localparam logic [WORD_W-1:0] STEP = WORD_W'(INSTR_BYTES);

  fetch_state_t      r_state;
  logic [WORD_W-1:0] r_pc;
  logic [WORD_W-1:0] r_req_addr;
  logic [WORD_W-1:0] r_skid_instr;
  logic [WORD_W-1:0] r_skid_pc2;
  logic              r_valid;
  logic [WORD_W-1:0] r_instr;
  logic [WORD_W-1:0] r_pc2;

  fetch_state_t      w_state_nxt;
  logic [WORD_W-1:0] w_pc_nxt;
  logic [WORD_W-1:0] w_req_addr_nxt;
  logic [WORD_W-1:0] w_skid_instr_nxt;
  logic [WORD_W-1:0] w_skid_pc2_nxt;
  logic              w_valid_nxt;
  logic [WORD_W-1:0] w_instr_nxt;
  logic [WORD_W-1:0] w_pc2_nxt;
  logic              w_load;
  logic [WORD_W-1:0] w_load_instr;
  logic [WORD_W-1:0] w_load_pc2;

  logic              w_slot_free;
  logic              w_ack;
  logic [WORD_W-1:0] w_target;
  logic [WORD_W-1:0] w_seq_pc;

  assign w_slot_free = !r_valid || !stall;
  assign w_ack       = imem.imem_ack;
  assign w_target    = {branch_target[WORD_W-1:1], 1'b0};
  assign w_seq_pc    = r_req_addr + STEP;

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_req_addr_nxt   = r_req_addr;
    w_skid_instr_nxt = r_skid_instr;
    w_skid_pc2_nxt   = r_skid_pc2;
    w_load           = 1'b0;
    w_load_instr     = imem.imem_rdata;
    w_load_pc2       = w_seq_pc;

    case (r_state)
      IDLE: begin
        w_state_nxt    = REQ;
        w_pc_nxt       = PC_Src ? w_target : r_pc;
        w_req_addr_nxt = PC_Src ? w_target : r_pc;
      end
      REQ: begin
        if (PC_Src) begin
          w_pc_nxt = w_target;
          if (w_ack) w_req_addr_nxt = w_target;
          else       w_state_nxt    = DROP;
        end else if (w_ack) begin
          w_pc_nxt       = w_seq_pc;
          w_req_addr_nxt = w_seq_pc;
          if (w_slot_free) begin
            w_load = 1'b1;
          end else begin
            w_skid_instr_nxt = imem.imem_rdata;
            w_skid_pc2_nxt   = w_seq_pc;
            w_state_nxt      = FULL;
          end
        end
      end
      DROP: begin
        // The stale response must complete before the bus address may move.
        if (PC_Src) w_pc_nxt = w_target;
        if (w_ack) begin
          w_state_nxt    = REQ;
          w_req_addr_nxt = PC_Src ? w_target : r_pc;
        end
      end
      FULL: begin
        if (PC_Src) begin
          w_pc_nxt         = w_target;
          w_req_addr_nxt   = w_target;
          w_skid_instr_nxt = '0;
          w_skid_pc2_nxt   = '0;
          w_state_nxt      = REQ;
        end else if (w_slot_free) begin
          w_load         = 1'b1;
          w_load_instr   = r_skid_instr;
          w_load_pc2     = r_skid_pc2;
          w_req_addr_nxt = r_pc;
          w_state_nxt    = REQ;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    w_valid_nxt = r_valid;
    w_instr_nxt = r_instr;
    w_pc2_nxt   = r_pc2;
    if (PC_Src) begin
      w_valid_nxt = 1'b0;
      w_instr_nxt = NOP_INSTR;
    end else if (w_load) begin
      w_valid_nxt = 1'b1;
      w_instr_nxt = w_load_instr;
      w_pc2_nxt   = w_load_pc2;
    end else if (r_valid && !stall) begin
      w_valid_nxt = 1'b0;
      w_instr_nxt = NOP_INSTR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_pc         <= RESET_PC;
      r_req_addr   <= RESET_PC;
      r_skid_instr <= '0;
      r_skid_pc2   <= '0;
      r_valid      <= 1'b0;
      r_instr      <= NOP_INSTR;
      r_pc2        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_req_addr   <= w_req_addr_nxt;
      r_skid_instr <= w_skid_instr_nxt;
      r_skid_pc2   <= w_skid_pc2_nxt;
      r_valid      <= w_valid_nxt;
      r_instr      <= w_instr_nxt;
      r_pc2        <= w_pc2_nxt;
    end
  end

  assign imem.imem_req  = (r_state == REQ) || (r_state == DROP);
  assign imem.imem_addr = r_req_addr;
  assign O_valid        = r_valid;
  assign O_instruction  = r_instr;
  assign O_PC_plus_two  = r_pc2;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed and random stimulus against an in-order fetch-stream model
module tb_instr_fetch_unit;

  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam logic [15:0] NOP      = 16'hF00D;

  logic        clk;
  logic        rst;
  logic        PC_Src;
  logic [15:0] branch_target;
  logic        stall;
  logic        O_valid;
  logic [15:0] O_instruction;
  logic [15:0] O_PC_plus_two;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .PC_Src        (PC_Src),
    .branch_target (branch_target),
    .stall         (stall),
    .imem          (bus),
    .O_valid       (O_valid),
    .O_instruction (O_instruction),
    .O_PC_plus_two (O_PC_plus_two)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          mem_lat = 1;
  int          wait_cnt = 0;
  int          idle_run = 0;
  int          max_idle = 0;
  int          n_xfer = 0;
  logic        pending = 1'b0;
  logic [15:0] pend_addr = '0;
  logic [15:0] exp_pc = RESET_PC;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a * 16'd7) ^ 16'h5A5A;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, answer the memory, score the stream.
  task automatic tick(input logic r, input logic src, input logic [15:0] tgt, input logic stl);
    @(negedge clk);
    rst = r;
    PC_Src = src;
    branch_target = tgt;
    stall = stl;
    if (r) begin
      bus.imem_ack = 1'b0;
      wait_cnt = 0;
      pending = 1'b0;
      exp_pc = RESET_PC;
      idle_run = 0;
    end else begin
      if (bus.imem_req) begin
        if (wait_cnt >= mem_lat - 1) begin
          bus.imem_ack = 1'b1;
          bus.imem_rdata = mem_word(bus.imem_addr);
          wait_cnt = 0;
        end else begin
          bus.imem_ack = 1'b0;
          bus.imem_rdata = 16'($urandom);
          wait_cnt++;
        end
      end else begin
        bus.imem_ack = 1'b0;
        wait_cnt = 0;
      end
      if (pending) begin
        check_eq("req_held", 32'(bus.imem_req), 32'd1);
        check_eq("addr_held", 32'(bus.imem_addr), 32'(pend_addr));
      end
      if (bus.imem_req) check_eq("addr_even", 32'(bus.imem_addr[0]), 32'd0);
      pending = bus.imem_req && !bus.imem_ack;
      pend_addr = bus.imem_addr;
      if (O_valid && !stl) begin
        check_eq("xfer_pc2", 32'(O_PC_plus_two), 32'(16'(exp_pc + 16'd2)));
        check_eq("xfer_instr", 32'(O_instruction), 32'(mem_word(exp_pc)));
        exp_pc = exp_pc + 16'd2;
        n_xfer++;
      end else if (!O_valid) begin
        check_eq("nop_when_invalid", 32'(O_instruction), 32'(NOP));
      end
      if (stl || src || O_valid) idle_run = 0;
      else idle_run++;
      if (idle_run > max_idle) max_idle = idle_run;
      if (src) exp_pc = tgt & 16'hFFFE;
    end
  endtask

  initial begin
    int          cnt;
    logic [15:0] frozen;
    logic        r;
    logic        src;
    logic        stl;

    rst = 1'b1;
    PC_Src = 1'b0;
    branch_target = '0;
    stall = 1'b0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;

    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    check_eq("rst_valid", 32'(O_valid), 32'd0);
    check_eq("rst_instr", 32'(O_instruction), 32'(NOP));
    check_eq("rst_pc2", 32'(O_PC_plus_two), 32'd0);
    check_eq("rst_req", 32'(bus.imem_req), 32'd0);
    check_eq("rst_addr", 32'(bus.imem_addr), 32'(RESET_PC));

    mem_lat = 1;
    tick(0, 0, 0, 0);
    check_eq("idle_req", 32'(bus.imem_req), 32'd0);
    tick(0, 0, 0, 0);
    check_eq("first_req", 32'(bus.imem_req), 32'd1);
    check_eq("first_addr", 32'(bus.imem_addr), 32'd0);
    check_eq("first_valid", 32'(O_valid), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      tick(0, 0, 0, 0);
      check_eq("seq_addr", 32'(bus.imem_addr), 32'(2 * k));
      check_eq("seq_valid", 32'(O_valid), 32'd1);
      check_eq("seq_pc2", 32'(O_PC_plus_two), 32'(2 * k));
    end

    mem_lat = 3;
    for (int k = 0; k < 6; k++) tick(0, 0, 0, 0);
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      tick(0, 0, 0, 0);
      if (O_valid) cnt++;
    end
    check_eq("lat3_pulses", 32'(cnt), 32'd10);

    mem_lat = 1;
    for (int k = 0; k < 6; k++) tick(0, 0, 0, 0);
    tick(0, 0, 0, 1);
    frozen = O_instruction;
    check_eq("stall_start_valid", 32'(O_valid), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick(0, 0, 0, 1);
      check_eq("stall_frozen", 32'(O_instruction), 32'(frozen));
      check_eq("stall_no_req", 32'(bus.imem_req), 32'd0);
    end
    for (int k = 0; k < 8; k++) tick(0, 0, 0, 0);

    mem_lat = 3;
    tick(0, 1, 16'h0010, 0);
    cnt = 0;
    do begin
      tick(0, 0, 0, 0);
      cnt++;
    end while (!(bus.imem_req && bus.imem_addr == 16'h0010) && cnt < 20);
    check_eq("reach_0010", 32'(cnt < 20), 32'd1);
    tick(0, 1, 16'h0040, 0);
    cnt = 0;
    do begin
      tick(0, 0, 0, 0);
      cnt++;
    end while (!(bus.imem_req && bus.imem_addr != 16'h0010) && cnt < 20);
    check_eq("redir_addr", 32'(bus.imem_addr), 32'h0040);
    cnt = 0;
    while (!O_valid && cnt < 20) begin
      tick(0, 0, 0, 0);
      cnt++;
    end
    check_eq("redir_valid", 32'(O_valid), 32'd1);
    check_eq("redir_pc2", 32'(O_PC_plus_two), 32'h0042);

    mem_lat = 1;
    for (int k = 0; k < 6; k++) tick(0, 0, 0, 0);
    tick(0, 0, 0, 1);
    tick(0, 1, 16'h0080, 1);
    tick(0, 0, 0, 0);
    check_eq("flush_valid", 32'(O_valid), 32'd0);
    check_eq("flush_addr", 32'(bus.imem_addr), 32'h0080);
    tick(0, 0, 0, 0);
    check_eq("flush_next_valid", 32'(O_valid), 32'd1);
    check_eq("flush_next_pc2", 32'(O_PC_plus_two), 32'h0082);

    tick(0, 1, 16'hFFFC, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    check_eq("wrap_pre_pc2", 32'(O_PC_plus_two), 32'hFFFE);
    tick(0, 0, 0, 0);
    check_eq("wrap_pc2", 32'(O_PC_plus_two), 32'h0000);
    check_eq("wrap_addr", 32'(bus.imem_addr), 32'h0000);

    n_xfer = 0;
    max_idle = 0;
    for (int k = 0; k < 1500; k++) begin
      r   = ($urandom_range(0, 199) == 0);
      src = !r && ($urandom_range(0, 19) == 0);
      stl = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 49) == 0) mem_lat = $urandom_range(1, 4);
      tick(r, src, 16'($urandom), stl);
    end
    check_eq("rand_progress", 32'(n_xfer > 100), 32'd1);
    check_eq("rand_idle_bound", 32'(max_idle <= 20), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
